// File: rtl/out_buff.sv
// Result-word output buffer: word FIFO feeding a byte serializer (MSB first) into the UART transmitter handshake.
// Optional OUT_BUFF_SYNC_BYTE_EN: prefix every word with header byte 8'hA5.
//
// state     | meaning
// IDLE      | waiting for a word in the FIFO
// LOAD      | current byte on toTx, waiting for transmitter idle
// SEND      | one-cycle wr_en pulse
// WAIT_ACK  | waiting for Tx_busy to rise (bounded by ACK_TIMEOUT)
// WAIT_DONE | waiting for Tx_busy to fall, then next byte or IDLE
module out_buff #(
  parameter int WORD_BYTES  = 4,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    clk_50m,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] result_in,
  input  logic                    result_valid,
  output logic                    result_ready,
  output logic [7:0]              toTx,
  output logic                    wr_en,
  input  logic                    Tx_busy,
  output logic                    busy,
  output logic                    empty,
  output logic                    overflow,
  output logic                    ack_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic            full, full_nxt, push, pop;
  logic [WW-1:0]   shreg;
  logic [CW-1:0]   byte_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            advance, set_err, hdr;

`ifdef OUT_BUFF_SYNC_BYTE_EN
  localparam logic [CW-1:0] START_CNT = CW'(WORD_BYTES);
  assign hdr = (byte_cnt == CW'(WORD_BYTES));
`else
  localparam logic [CW-1:0] START_CNT = CW'(WORD_BYTES - 1);
  assign hdr = 1'b0;
`endif

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = result_valid && result_ready;

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
  assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  assign toTx = hdr ? 8'hA5 : shreg[WW-1 -: 8];

  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr[AW-1:0]] <= result_in;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    advance   = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:      if (!Tx_busy) state_nxt = SEND;
      SEND:      state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (Tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == '0) begin
          set_err   = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!Tx_busy) begin
          if (byte_cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wr_en and busy are registered from the next state so they never glitch
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      result_ready <= 1'b1;
      overflow     <= 1'b0;
      ack_err      <= 1'b0;
      shreg        <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      wr_en        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      result_ready <= !full_nxt;
      wr_en        <= (state_nxt == SEND);
      busy         <= (state_nxt != IDLE);
      if (result_valid && full) overflow <= 1'b1;
      if (set_err) ack_err <= 1'b1;
      if (pop) begin
        shreg    <= mem[rd_ptr[AW-1:0]];
        byte_cnt <= START_CNT;
      end else if (advance) begin
        if (!hdr) shreg <= shreg << 8;
        byte_cnt <= byte_cnt - CW'(1);
      end
      if (state == SEND) begin
        tmo_cnt <= TW'(ACK_TIMEOUT - 1);
      end else if (state == WAIT_ACK && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TW'(1);
      end
    end
  end
endmodule
